cdb_arbiter: RTL and testbench

//  Grant side of the data-bus request/permit handshake. Each functional-unit output

---
 rtl/cdb_arbiter_if.sv | 48 ++++
 rtl/cdb_arbiter.sv | 121 ++++++++++++
 tb/tb_cdb_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
//   Request/permit bundle between N functional-unit output buffers and the
//   data-bus arbiter.
//   Signals:
//     not_empty[N]       requester i has a result to broadcast
//     full[N]            requester i buffer is full
//     hold               bus reserved this cycle, suppress all grants
//     permit[N]          one-hot (or zero) combinational grant
//     data_bus_active    |permit
//     grant_index        encoded permit index, 0 when no grant
//     last_grant_index   round-robin pointer (debug visibility)
//   Modports:
//     master  requester side (drives requests, observes grants)
//     slave   arbiter side   (observes requests, drives grants)
// ---------------------------------------------------------------------------
interface cdb_arbiter_if #(
    parameter int N         = 4,
    parameter int IDX_WIDTH = $clog2(N)
);
    logic [N-1:0]         not_empty;
    logic [N-1:0]         full;
    logic                 hold;
    logic [N-1:0]         permit;
    logic                 data_bus_active;
    logic [IDX_WIDTH-1:0] grant_index;
    logic [IDX_WIDTH-1:0] last_grant_index;

    modport master (
        output not_empty,
        output full,
        output hold,
        input  permit,
        input  data_bus_active,
        input  grant_index,
        input  last_grant_index
    );

    modport slave (
        input  not_empty,
        input  full,
        input  hold,
        output permit,
        output data_bus_active,
        output grant_index,
        output last_grant_index
    );
endinterface

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//   Zero-latency grant side of the data-bus request/permit handshake. The
//   permit is decided combinationally in the request cycle; the granted
//   buffer retires its entry at the following edge.
//   Priority: starved requesters first, then full buffers, then plain
//   round-robin. All tiers are searched circularly starting one past the
//   last granted index.
//   Ports:
//     clk     clock, all state updates on posedge
//     reset   synchronous, active-high
//     bus     cdb_arbiter_if slave modport (requests in, grants out)
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int N            = 4,
    parameter int STARVE_LIMIT = 3,
    parameter int IDX_WIDTH    = $clog2(N),
    parameter int CNT_WIDTH    = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0] LIMIT_C    = CNT_WIDTH'(STARVE_LIMIT);
    localparam logic [IDX_WIDTH-1:0] PTR_INIT_C = IDX_WIDTH'(N - 1);
    localparam logic [N-1:0]         ONE_C      = {{(N-1){1'b0}}, 1'b1};

    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0] cnt_q [N];
    logic [CNT_WIDTH-1:0] cnt_d [N];

    logic [N-1:0]         starved;
    logic [N-1:0]         sel;
    logic [N-1:0]         permit_d;
    logic [IDX_WIDTH-1:0] grant_d;
    logic [IDX_WIDTH-1:0] idx_w;
    logic                 found;
    int                   start;
    int                   idx;

    // Grant decision: pick the highest non-empty tier, then the first
    // member of that tier in circular order from ptr_q+1.
    always_comb begin
        starved  = '0;
        sel      = '0;
        permit_d = '0;
        grant_d  = '0;
        idx_w    = '0;
        found    = 1'b0;
        idx      = 0;

        for (int i = 0; i < N; i++) begin
            starved[i] = bus.not_empty[i] && (cnt_q[i] == LIMIT_C);
        end

        if (|starved) begin
            sel = starved;
        end else if (|(bus.not_empty & bus.full)) begin
            sel = bus.not_empty & bus.full;
        end else begin
            sel = bus.not_empty;
        end

        // Modulo wrap keeps non-power-of-2 N from indexing past N-1.
        start = (int'(ptr_q) + 1) % N;
        for (int k = 0; k < N; k++) begin
            idx   = (start + k) % N;
            idx_w = IDX_WIDTH'(idx);
            if (!found && sel[idx_w]) begin
                found   = 1'b1;
                grant_d = idx_w;
            end
        end

        if (reset || bus.hold) begin
            found   = 1'b0;
            grant_d = '0;
        end

        permit_d = found ? (ONE_C << grant_d) : '0;
    end

    // Next-state for pointer and starvation counters.
    always_comb begin
        ptr_d = found ? grant_d : ptr_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (permit_d[i]) begin
                cnt_d[i] = '0;
            end else if (bus.not_empty[i] && !bus.hold) begin
                // Saturate at the limit so the requester stays in tier 1.
                if (cnt_q[i] != LIMIT_C) begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end else if (!bus.not_empty[i]) begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= PTR_INIT_C;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.permit           = permit_d;
    assign bus.data_bus_active  = |permit_d;
    assign bus.grant_index      = grant_d;
    assign bus.last_grant_index = ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//   Scoreboard bench for cdb_arbiter (N=4, STARVE_LIMIT=3). The driver
//   applies each cycle's requests, asks a priority-scoring reference model
//   for the expected grant and queues it; the monitor pops one entry per
//   cycle at the falling edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int N     = 4;
    localparam int LIMIT = 3;
    localparam int IW    = 2;

    typedef struct {
        logic [N-1:0]  permit;
        logic [IW-1:0] gi;
        logic [IW-1:0] ptr;
        bit            ptr_known;
        bit            has_const;
        logic [N-1:0]  const_p;
        logic [N-1:0]  ne;
        bit            hold;
        bit            rst;
    } exp_t;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    exp_t q[$];

    cdb_arbiter_if #(.N(N)) bus ();

    cdb_arbiter #(.N(N), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: pointer, waiting counts, and whether the
    // pointer is known yet (before the first reset edge it is not).
    int m_ptr = N - 1;
    int m_cnt [N];
    bit m_known = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each non-empty requester gets a score (3 starved, 2 full, 1 plain);
    // the highest score wins, ties going to whoever comes first in the
    // circular order after the pointer.
    task automatic model_eval(input logic [N-1:0] ne, input logic [N-1:0] fl,
                              input bit hold, input bit rst,
                              output logic [N-1:0] p, output logic [IW-1:0] gi);
        int best_score;
        int best;
        int i;
        int score;
        best_score = 0;
        best       = 0;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + 1 + k) % N;
            if (ne[i]) begin
                score = (m_cnt[i] >= LIMIT) ? 3 : (fl[i] ? 2 : 1);
                if (score > best_score) begin
                    best_score = score;
                    best       = i;
                end
            end
        end
        p  = '0;
        gi = '0;
        if (!rst && !hold && best_score > 0) begin
            p[best] = 1'b1;
            gi      = IW'(best);
        end
    endtask

    task automatic model_update(input logic [N-1:0] ne, input bit hold, input bit rst,
                                input logic [N-1:0] p, input logic [IW-1:0] gi);
        if (rst) begin
            m_ptr   = N - 1;
            m_known = 1'b1;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (p[i])                m_cnt[i] = 0;
                else if (ne[i] && !hold) m_cnt[i] = (m_cnt[i] + 1 > LIMIT) ? LIMIT : m_cnt[i] + 1;
                else if (!ne[i])         m_cnt[i] = 0;
            end
            if (p != '0) m_ptr = int'(gi);
        end
    endtask

    // One cycle of stimulus; const_p >= 0 adds a hand-computed permit check.
    task automatic step(input bit rst, input logic [N-1:0] ne, input logic [N-1:0] fl,
                        input bit hold, input int const_p);
        exp_t e;
        reset         = rst;
        bus.not_empty = ne;
        bus.full      = fl;
        bus.hold      = hold;
        model_eval(ne, fl, hold, rst, e.permit, e.gi);
        e.ptr       = IW'(m_ptr);
        e.ptr_known = m_known;
        e.has_const = (const_p >= 0);
        e.const_p   = N'(const_p);
        e.ne        = ne;
        e.hold      = hold;
        e.rst       = rst;
        q.push_back(e);
        model_update(ne, hold, rst, e.permit, e.gi);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one queued expectation per cycle, checked at the falling edge.
    int wait_cyc [N];
    initial begin
        exp_t e;
        for (int i = 0; i < N; i++) wait_cyc[i] = 0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("permit", 32'(bus.permit), 32'(e.permit));
                chk("grant_index", 32'(bus.grant_index), 32'(e.gi));
                chk("data_bus_active", 32'(bus.data_bus_active), 32'(e.permit != '0));
                if (e.ptr_known)
                    chk("last_grant_index", 32'(bus.last_grant_index), 32'(e.ptr));
                if (e.has_const)
                    chk("permit_directed", 32'(bus.permit), 32'(e.const_p));
                chk("onehot0", 32'($onehot0(bus.permit)), 32'(1));
                chk("subset", 32'(bus.permit & ~e.ne), 32'(0));
                for (int i = 0; i < N; i++) begin
                    if (e.rst || !e.ne[i] || bus.permit[i]) wait_cyc[i] = 0;
                    else if (!e.hold) wait_cyc[i]++;
                    if (wait_cyc[i] > N + LIMIT) begin
                        errors++;
                        $display("FAIL starvation: req %0d waited %0d required <= %0d", i, wait_cyc[i], N + LIMIT);
                        wait_cyc[i] = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [N-1:0] ne, fl;
        bit hold, rst;
        reset         = 1'b1;
        bus.not_empty = '0;
        bus.full      = '0;
        bus.hold      = 1'b0;
        @(posedge clk);
        #1;

        // Reset state, including reset with requests pending.
        step(1, 4'b1111, 4'b0000, 0, 0);
        step(1, 4'b0000, 4'b0000, 0, 0);

        // Round-robin between two requesters.
        step(0, 4'b0101, 4'b0000, 0, 4'b0001);
        step(0, 4'b0101, 4'b0000, 0, 4'b0100);
        step(0, 4'b0101, 4'b0000, 0, 4'b0001);
        step(0, 4'b0101, 4'b0000, 0, 4'b0100);

        // Full buffer has priority.
        step(1, 4'b0000, 4'b0000, 0, 0);
        step(0, 4'b1111, 4'b0100, 0, 4'b0100);
        step(0, 4'b1111, 4'b0100, 0, 4'b0100);

        // Starvation overrides a persistently full buffer.
        step(1, 4'b0000, 4'b0000, 0, 0);
        step(0, 4'b1111, 4'b0010, 0, 4'b0010);
        step(0, 4'b1111, 4'b0010, 0, 4'b0010);
        step(0, 4'b1111, 4'b0010, 0, 4'b0010);
        step(0, 4'b1111, 4'b0010, 0, 4'b0100);
        step(0, 4'b1111, 4'b0010, 0, 4'b1000);
        step(0, 4'b1111, 4'b0010, 0, 4'b0001);
        step(0, 4'b1111, 4'b0010, 0, 4'b0010);

        // Hold suppresses grants; pointer and counters hold.
        step(1, 4'b0000, 4'b0000, 0, 0);
        step(0, 4'b1111, 4'b0000, 1, 4'b0000);
        step(0, 4'b1111, 4'b0000, 1, 4'b0000);
        step(0, 4'b1111, 4'b0000, 0, 4'b0001);
        step(0, 4'b1111, 4'b0000, 0, 4'b0010);

        // Reset mid-burst drops permit that cycle, then restarts at 0.
        step(0, 4'b1111, 4'b0000, 0, 4'b0100);
        step(1, 4'b1111, 4'b0000, 0, 4'b0000);
        step(0, 4'b1111, 4'b0000, 0, 4'b0001);

        // Single requester granted every cycle.
        step(0, 4'b1000, 4'b0000, 0, 4'b1000);
        step(0, 4'b1000, 4'b1000, 0, 4'b1000);
        step(0, 4'b1000, 4'b0000, 0, 4'b1000);

        // All full: plain round-robin.
        step(0, 4'b1111, 4'b1111, 0, 4'b0001);
        step(0, 4'b1111, 4'b1111, 0, 4'b0010);
        step(0, 4'b1111, 4'b1111, 0, 4'b0100);

        // Randomized traffic.
        for (int c = 0; c < 10000; c++) begin
            ne   = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'b1111 & N'($urandom | $urandom);
            fl   = N'($urandom & $urandom);
            hold = ($urandom_range(0, 9) == 0);
            rst  = ($urandom_range(0, 299) == 0);
            step(rst, ne, fl, hold, -1);
        end

        for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
